// File: rtl/noc_resp_pkg.sv
// rtl/noc_resp_pkg.sv - shared flit-type, state and sizing helpers for the response packetizer
package noc_resp_pkg;

  typedef enum logic [1:0] {
    FT_BODY     = 2'b00,
    FT_HEAD     = 2'b01,
    FT_TAIL     = 2'b10,
    FT_HEADTAIL = 2'b11
  } ftype_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_FETCH
  } state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/flit_slicer.sv
// rtl/flit_slicer.sv - selects slice idx of a wide vector, zero-padded past its top bit
module flit_slicer #(
  parameter int IN_WIDTH    = 60,
  parameter int SLICE_WIDTH = 30,
  parameter int NSLICE      = 2,
  parameter int IDX_W       = 1
) (
  input  logic [IN_WIDTH-1:0]    vec_i,
  input  logic [IDX_W-1:0]       idx_i,
  output logic [SLICE_WIDTH-1:0] slice_o
);

  localparam int PAD_W = NSLICE * SLICE_WIDTH;

  logic [PAD_W-1:0] padded;

  assign padded = PAD_W'(vec_i);

  always_comb begin
    slice_o = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (idx_i == IDX_W'(k)) slice_o = padded[k*SLICE_WIDTH +: SLICE_WIDTH];
    end
  end

endmodule

// File: rtl/axi_ni_resp_packetizer.sv
// rtl/axi_ni_resp_packetizer.sv - serialises a response header plus AXI B/R beats into NoC flits
module axi_ni_resp_packetizer
  import noc_resp_pkg::*;
#(
  parameter int FLIT_WIDTH   = 32,
  parameter int FTYPEWD      = 2,
  parameter int HEADER_WIDTH = 60,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_BEATS    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hdr_valid,
  input  logic                    is_read,
  input  logic [HEADER_WIDTH-1:0] header,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [1:0]              bresp,
  input  logic                    r_valid,
  output logic                    r_ready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  output logic                    flit_valid,
  input  logic                    flit_ready,
  output logic [FLIT_WIDTH-1:0]   flit,
  output logic                    resp_done,
  output logic                    beat_overflow
);

  localparam int BASE_WIDTH = FLIT_WIDTH - FTYPEWD;
  localparam int BEAT_WIDTH = DATA_WIDTH + 2;
  localparam int HDR_FLITS  = ceil_div(HEADER_WIDTH, BASE_WIDTH);
  localparam int BEAT_FLITS = ceil_div(BEAT_WIDTH, BASE_WIDTH);
  localparam int HCW        = (HDR_FLITS > 1) ? $clog2(HDR_FLITS) : 1;
  localparam int PCW        = (BEAT_FLITS > 1) ? $clog2(BEAT_FLITS) : 1;
  localparam int BCW        = $clog2(MAX_BEATS + 1);

  state_e                  state_q, state_d;
  logic [HEADER_WIDTH-1:0] hdr_q, hdr_d;
  logic [BEAT_WIDTH-1:0]   beat_q, beat_d;
  logic                    last_q, last_d;
  logic                    is_read_q, is_read_d;
  logic [HCW-1:0]          hdr_cnt_q, hdr_cnt_d;
  logic [PCW-1:0]          pay_cnt_q, pay_cnt_d;
  logic [BCW-1:0]          beat_cnt_q, beat_cnt_d;
  logic                    flit_valid_q, flit_valid_d;
  logic [FLIT_WIDTH-1:0]   flit_q, flit_d;
  logic                    resp_done_q, resp_done_d;
  logic                    overflow_q, overflow_d;

  logic                  start, accept, hdr_final, pay_final, pay_final_d;
  logic [BASE_WIDTH-1:0] hdr_slice, beat_slice;

  // A packet only opens once its first payload is in hand, so the NoC never stalls on a bare header.
  assign start     = ~rst & (state_q == ST_IDLE) & hdr_valid & (is_read ? r_valid : b_valid);
  assign accept    = flit_valid_q & flit_ready;
  assign hdr_final = (hdr_cnt_q == HCW'(HDR_FLITS - 1));
  assign pay_final = (pay_cnt_q == (is_read_q ? PCW'(BEAT_FLITS - 1) : PCW'(0)));

  assign b_ready = start & ~is_read;
  assign r_ready = (start & is_read) | (~rst & (state_q == ST_FETCH));

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    beat_d      = beat_q;
    last_d      = last_q;
    is_read_d   = is_read_q;
    hdr_cnt_d   = hdr_cnt_q;
    pay_cnt_d   = pay_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    overflow_d  = overflow_q;
    resp_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          hdr_d      = header;
          is_read_d  = is_read;
          beat_d     = is_read ? {rresp, rdata} : BEAT_WIDTH'(bresp);
          last_d     = is_read ? rlast : 1'b1;
          beat_cnt_d = BCW'(1);
          hdr_cnt_d  = '0;
          state_d    = ST_HDR;
          if (is_read && !rlast && beat_cnt_d == BCW'(MAX_BEATS)) begin
            last_d     = 1'b1;
            overflow_d = 1'b1;
          end
        end
      end
      ST_HDR: begin
        if (accept) begin
          if (hdr_final) begin
            pay_cnt_d = '0;
            state_d   = ST_PAY;
          end else begin
            hdr_cnt_d = hdr_cnt_q + 1'b1;
          end
        end
      end
      ST_PAY: begin
        if (accept) begin
          if (!pay_final) begin
            pay_cnt_d = pay_cnt_q + 1'b1;
          end else if (last_q) begin
            resp_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (r_valid) begin
          beat_d     = {rresp, rdata};
          last_d     = rlast;
          beat_cnt_d = beat_cnt_q + 1'b1;
          pay_cnt_d  = '0;
          state_d    = ST_PAY;
          if (!rlast && beat_cnt_d == BCW'(MAX_BEATS)) begin
            last_d     = 1'b1;
            overflow_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  flit_slicer #(
    .IN_WIDTH(HEADER_WIDTH), .SLICE_WIDTH(BASE_WIDTH), .NSLICE(HDR_FLITS), .IDX_W(HCW)
  ) u_hdr_slicer (
    .vec_i(hdr_d), .idx_i(hdr_cnt_d), .slice_o(hdr_slice)
  );

  flit_slicer #(
    .IN_WIDTH(BEAT_WIDTH), .SLICE_WIDTH(BASE_WIDTH), .NSLICE(BEAT_FLITS), .IDX_W(PCW)
  ) u_beat_slicer (
    .vec_i(beat_d), .idx_i(pay_cnt_d), .slice_o(beat_slice)
  );

  // The output flit is built from next-state values; while stalled those are unchanged, so flit holds.
  always_comb begin
    flit_valid_d = (state_d == ST_HDR) || (state_d == ST_PAY);
    flit_d       = flit_q;
    pay_final_d  = (pay_cnt_d == (is_read_d ? PCW'(BEAT_FLITS - 1) : PCW'(0)));
    if (state_d == ST_HDR) begin
      flit_d = {FTYPEWD'((hdr_cnt_d == '0) ? FT_HEAD : FT_BODY), hdr_slice};
    end else if (state_d == ST_PAY) begin
      flit_d = {FTYPEWD'((pay_final_d && last_d) ? FT_TAIL : FT_BODY), beat_slice};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hdr_q        <= '0;
      beat_q       <= '0;
      last_q       <= 1'b0;
      is_read_q    <= 1'b0;
      hdr_cnt_q    <= '0;
      pay_cnt_q    <= '0;
      beat_cnt_q   <= '0;
      flit_valid_q <= 1'b0;
      flit_q       <= '0;
      resp_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      beat_q       <= beat_d;
      last_q       <= last_d;
      is_read_q    <= is_read_d;
      hdr_cnt_q    <= hdr_cnt_d;
      pay_cnt_q    <= pay_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      flit_valid_q <= flit_valid_d;
      flit_q       <= flit_d;
      resp_done_q  <= resp_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign flit_valid    = flit_valid_q;
  assign flit          = flit_q;
  assign resp_done     = resp_done_q;
  assign beat_overflow = overflow_q;

endmodule

// File: tb/tb_axi_ni_resp_packetizer.sv
// tb/tb_axi_ni_resp_packetizer.sv - scoreboard bench for the response packetizer
module tb_axi_ni_resp_packetizer;
  import noc_resp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        hdr_valid, is_read;
  logic [59:0] header;
  logic        b_valid, b_ready;
  logic [1:0]  bresp;
  logic        r_valid, r_ready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        flit_valid, flit_ready;
  logic [31:0] flit;
  logic        resp_done, beat_overflow;

  axi_ni_resp_packetizer dut (
    .clk(clk), .rst(rst), .hdr_valid(hdr_valid), .is_read(is_read), .header(header),
    .b_valid(b_valid), .b_ready(b_ready), .bresp(bresp),
    .r_valid(r_valid), .r_ready(r_ready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .flit(flit),
    .resp_done(resp_done), .beat_overflow(beat_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_flits = 0;
  int done_cnt = 0;
  int rr_cnt = 0;
  int tail_cyc = -100;
  int first_fv = -1;
  int start_cyc = 0;
  bit rdy_mode = 1'b0;
  logic        held_v = 1'b0;
  logic [31:0] held_f;
  logic [31:0] exp_f;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [59:0] rand_hdr();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[59:0];
  endfunction

  function automatic void push_hdr(input logic [59:0] h);
    exp_q.push_back({2'b01, h[29:0]});
    exp_q.push_back({2'b00, h[59:30]});
  endfunction

  function automatic void push_beat(input logic [33:0] v, input bit last);
    exp_q.push_back({2'b00, v[29:0]});
    exp_q.push_back({(last ? 2'b10 : 2'b00), 26'd0, v[33:30]});
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    flit_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      flit_ready = rdy_mode ? ~flit_ready : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) check_eq("flit_stable", {flit_valid, flit}, {1'b1, held_f});
      if (flit_valid && flit_ready) begin
        if (exp_q.size() == 0) check_eq("sb_underflow", exp_q.size(), 1);
        else begin
          exp_f = exp_q.pop_front();
          check_eq("flit", flit, exp_f);
        end
        n_flits++;
        if (flit[31:30] == 2'b10) tail_cyc = cyc;
      end
      held_v = flit_valid && !flit_ready;
      held_f = flit;
      if (r_ready) rr_cnt++;
      if (flit_valid && first_fv < 0) first_fv = cyc;
      if (resp_done) begin
        check_eq("done_lat", cyc - tail_cyc, 1);
        done_cnt++;
      end
    end
  end

  task automatic wait_done();
    int to = 0;
    @(negedge clk);
    while (!resp_done && to < 500) begin
      @(negedge clk);
      to++;
    end
    if (!resp_done) check_eq("done_timeout", resp_done, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [59:0] h, input logic [1:0] br);
    int to = 0;
    int nf0 = n_flits;
    int d0 = done_cnt;
    push_hdr(h);
    exp_q.push_back({2'b10, 28'd0, br});
    @(posedge clk); #1;
    hdr_valid = 1'b1; is_read = 1'b0; header = h; bresp = br; b_valid = 1'b1;
    @(negedge clk);
    while (!b_ready && to < 100) begin
      @(negedge clk);
      to++;
    end
    if (!b_ready) check_eq("b_hs_timeout", b_ready, 1);
    @(posedge clk); #1;
    b_valid = 1'b0;
    wait_done();
    hdr_valid = 1'b0;
    check_eq("wr_flits", n_flits - nf0, 3);
    check_eq("wr_done", done_cnt - d0, 1);
  endtask

  task automatic do_read(input logic [59:0] h, input int nb, input bit give_last,
                         input int hold, input logic [1:0] rr, input int exp_rr);
    int to;
    int fv_seen = 0;
    int nf0 = n_flits;
    int d0 = done_cnt;
    push_hdr(h);
    for (int b = 0; b < nb; b++) push_beat({rr, 32'hA0 + 32'(b)}, b == nb - 1);
    @(posedge clk); #1;
    hdr_valid = 1'b1; is_read = 1'b1; header = h; r_valid = 1'b0;
    first_fv = -1;
    rr_cnt = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (flit_valid) fv_seen++;
    end
    if (hold > 0) begin
      check_eq("hold_no_flit", fv_seen, 0);
      @(posedge clk); #1;
    end
    for (int b = 0; b < nb; b++) begin
      rdata = 32'hA0 + 32'(b); rresp = rr; rlast = give_last && (b == nb - 1); r_valid = 1'b1;
      to = 0;
      @(negedge clk);
      while (!r_ready && to < 200) begin
        @(negedge clk);
        to++;
      end
      if (!r_ready) check_eq("r_hs_timeout", r_ready, 1);
      if (b == 0) start_cyc = cyc;
      @(posedge clk); #1;
    end
    r_valid = 1'b0; rlast = 1'b0;
    wait_done();
    hdr_valid = 1'b0;
    check_eq("rd_start_lat", first_fv - start_cyc, 1);
    check_eq("rd_flits", n_flits - nf0, 2 + 2 * nb);
    check_eq("rd_done", done_cnt - d0, 1);
    if (exp_rr > 0) check_eq("rd_rready_cycles", rr_cnt, exp_rr);
  endtask

  initial begin
    int to;
    int nf0;
    logic [59:0] h;
    rst = 1'b1;
    hdr_valid = 1'b0; is_read = 1'b0; header = '0;
    b_valid = 1'b0; bresp = '0; r_valid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_outs", {flit_valid, b_ready, r_ready, resp_done, beat_overflow}, 5'b0);
    check_eq("rst_flit", flit, 32'h0);

    do_write(60'h0123_4567_89AB_CDE, 2'b10);
    do_read(rand_hdr(), 4, 1'b1, 0, 2'b00, 4);

    rdy_mode = 1'b1;
    do_read(rand_hdr(), 2, 1'b1, 0, 2'b01, 0);
    rdy_mode = 1'b0;

    do_read(rand_hdr(), 1, 1'b1, 20, 2'b11, 0);

    check_eq("ovf_pre", beat_overflow, 0);
    do_read(rand_hdr(), 16, 1'b0, 0, 2'b00, 0);
    check_eq("ovf_set", beat_overflow, 1);

    // reset while the beat register is being emitted
    h = rand_hdr();
    nf0 = n_flits;
    push_hdr(h);
    push_beat({2'b00, 32'hB0}, 1'b0);
    push_beat({2'b00, 32'hB1}, 1'b1);
    @(posedge clk); #1;
    hdr_valid = 1'b1; is_read = 1'b1; header = h;
    rdata = 32'hB0; rresp = 2'b00; rlast = 1'b0; r_valid = 1'b1;
    to = 0;
    @(negedge clk);
    while (!r_ready && to < 100) begin
      @(negedge clk);
      to++;
    end
    if (!r_ready) check_eq("rst_hs_timeout", r_ready, 1);
    @(posedge clk); #1;
    rdata = 32'hB1; rlast = 1'b1;
    to = 0;
    while (n_flits < nf0 + 3 && to < 100) begin
      @(negedge clk); #1;
      to++;
    end
    check_eq("rst_pre_flits", n_flits - nf0, 3);
    @(posedge clk); #1;
    rst = 1'b1; hdr_valid = 1'b0; r_valid = 1'b0; rlast = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_mid_fv", flit_valid, 0);
    check_eq("rst_mid_state", dut.state_q, ST_IDLE);
    check_eq("rst_mid_outs", {b_ready, resp_done, beat_overflow}, 3'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_write(rand_hdr(), 2'b01);

    repeat (3) @(negedge clk);
    check_eq("sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
